// File: rtl/bc_polinomio_if.sv
// bc_polinomio_if: start/mode request plus mux-select, load-enable and status lines between controller and datapath
//   master: drives start, mode; observes m0/m1/m2, lx/ls/lh, h, busy, done
//   slave : the controller side (bc_polinomio)
interface bc_polinomio_if;
  logic       start;
  logic       mode;
  logic [1:0] m0;
  logic [1:0] m1;
  logic [1:0] m2;
  logic       lx;
  logic       ls;
  logic       lh;
  logic       h;
  logic       busy;
  logic       done;
  modport master (output start, mode, input m0, m1, m2, lx, ls, lh, h, busy, done);
  modport slave  (input start, mode, output m0, m1, m2, lx, ls, lh, h, busy, done);
endinterface

// File: rtl/bc_polinomio.sv
// bc_polinomio: Moore controller sequencing a 16-bit ALU datapath through A*X^2+B*X+C (mode 0) or (A*X+B)*(C+X) (mode 1)
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset
//   bus : slave side of bc_polinomio_if (start/mode in; m0/m1/m2, lx/ls/lh, h, busy, done out)
module bc_polinomio (
  input logic clk,
  input logic rst,
  bc_polinomio_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LDX, OP1, OP2, OP3, OP4, DONE} state_t;
  state_t st, nx;
  logic md;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= IDLE;
      md <= 1'b0;
    end else begin
      st <= nx;
      if (st == IDLE && bus.start) md <= bus.mode;
    end
  // Outputs depend only on the state and the latched mode; the unused encoding
  // falls through to the all-zero default and returns to IDLE.
  always_comb begin
    nx       = IDLE;
    bus.m0   = 2'd0;
    bus.m1   = 2'd0;
    bus.m2   = 2'd0;
    bus.lx   = 1'b0;
    bus.ls   = 1'b0;
    bus.lh   = 1'b0;
    bus.h    = 1'b0;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (st)
      IDLE: nx = bus.start ? LDX : IDLE;
      LDX: begin
        nx       = OP1;
        bus.busy = 1'b1;
        bus.lx   = 1'b1;
      end
      OP1: begin
        nx       = OP2;
        bus.busy = 1'b1;
        bus.h    = 1'b1;
        bus.ls   = 1'b1;
      end
      OP2: begin
        nx       = OP3;
        bus.busy = 1'b1;
        bus.m0   = 2'd2;
        bus.m1   = 2'd2;
        bus.m2   = 2'd1;
        bus.ls   = 1'b1;
      end
      OP3: begin
        nx       = OP4;
        bus.busy = 1'b1;
        bus.m0   = md ? 2'd3 : 2'd0;
        bus.m1   = md ? 2'd1 : 2'd2;
        bus.m2   = md ? 2'd1 : 2'd0;
        bus.h    = ~md;
        bus.ls   = ~md;
        bus.lh   = md;
      end
      OP4: begin
        nx       = DONE;
        bus.busy = 1'b1;
        bus.m0   = md ? 2'd0 : 2'd3;
        bus.m1   = 2'd2;
        bus.m2   = md ? 2'd3 : 2'd1;
        bus.h    = md;
        bus.ls   = 1'b1;
      end
      DONE: bus.done = 1'b1;
      default: nx = IDLE;
    endcase
  end
endmodule

// File: doc/bc_polinomio.md
BC_POLINOMIO -- requirements
Module: bc_polinomio

Interface
REQ-001 The parameter list SHALL be empty: the op count, encodings and sequence are fixed by this spec.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 start  input  1  request a new evaluation; sampled only in IDLE.
REQ-005 mode  input  1  0 = A*X^2+B*X+C (Horner); 1 = (A*X+B)*(C+X); latched when start is accepted.
REQ-006 m0  output  2  operand select: 0/1 = A, 2 = B, 3 = C.
REQ-007 m1  output  2  ULA operand 2 select: 0 = m0 operand, 1 = R0(X), 2 = R1(S), 3 = R2(H).
REQ-008 m2  output  2  ULA operand 1 select: 0 = R0(X), 1 = m0 operand, 2 = R1(S), 3 = R2(H).
REQ-009 lx, ls, lh  output  1 each  load enables for R0 (X), R1 (S/resultado), R2 (H).
REQ-010 h  output  1  ULA op: 0 = add, 1 = multiply.
REQ-011 busy  output  1  high in every state except IDLE and DONE.
REQ-012 done  output  1  high for exactly one cycle when the result is valid in R1.

Function
REQ-013 Controller SHALL be a Moore FSM; all outputs SHALL decode from the state register only.
REQ-014 States SHALL be IDLE, LDX, OP1, OP2, OP3, OP4, DONE; mode register SHALL be 1 bit.
REQ-015 In any state, outputs not listed for that state SHALL be 0: m0=m1=m2=0, lx=ls=lh=h=0.
REQ-016 IDLE: start=1 at edge -> LDX and latch mode; start=0 -> stay IDLE.
REQ-017 LDX: lx=1; next OP1.
REQ-018 OP1 (both modes): m0=0, m1=0, m2=0, h=1, ls=1 (S = A*X); next OP2.
REQ-019 OP2 (both modes): m0=2, m1=2, m2=1, h=0, ls=1 (S = B+S); next OP3.
REQ-020 OP3 mode 0: m1=2, m2=0, h=1, ls=1 (S = X*S); mode 1: m0=3, m1=1, m2=1, h=0, lh=1 (H = C+X); next OP4.
REQ-021 OP4 mode 0: m0=3, m1=2, m2=1, h=0, ls=1 (S = C+S); mode 1: m1=2, m2=3, h=1, ls=1 (S = H*S); next DONE.
REQ-022 DONE: done=1; next IDLE unconditionally.
REQ-023 Latency: start accepted at edge k -> done high during cycle k+6; earliest restart accepted at edge k+7.
REQ-024 start during busy or DONE SHALL be ignored and SHALL NOT be queued; mode changes after acceptance SHALL have no effect.
REQ-025 Arithmetic width and wrap-around (16-bit, modulo 2^16) SHALL be the datapath's; controller SHALL NOT alter them.
REQ-026 Exactly one of lx/ls/lh SHALL be high in LDX and OP1-OP4, and none in IDLE/DONE.
REQ-027 Unused state encodings SHALL transition to IDLE on the next edge with all outputs 0.

Reset
REQ-028 rst=0 SHALL force state IDLE, mode register 0 and all outputs 0 immediately, independent of clk.
REQ-029 Reset mid-sequence SHALL abort without done; R0-R2 contents are not restored by this block.
REQ-030 After rst returns to 1, first acceptance SHALL require start=1 at a subsequent rising edge.

Verification
REQ-031 Mode 0, A=2 B=3 C=4 X=5, start one cycle -> done at k+6, resultado = 69 (0x0045).
REQ-032 Mode 1, same operands -> resultado = (10+3)*(4+5) = 117 (0x0075); lh high only in OP3.
REQ-033 Mode 0, A=0x0100 B=0 C=1 X=0x0100 -> resultado = 0x0001 (16-bit wrap of A*X^2).
REQ-034 start held high continuously -> evaluations back-to-back, done every 7 cycles, no extra pulses.
REQ-035 rst=0 asserted between edges during OP2 -> outputs 0 immediately, no done; rerun yields correct result.
REQ-036 mode toggled during OP1-OP4 -> result matches mode latched at acceptance; per-state output vectors match REQ-017..REQ-022 exactly.
